// File: rtl/cache_set.sv
// One set of a WAYS-way associative cache: tag match, word read/store, LRU ages, victim select and refill.
// Optional macro CACHE_WSTRB_EN: when defined, store byte enables come from wstrb_i; otherwise stores write all bytes.
`ifndef CACHE_T
`define CACHE_T 20
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_set #(
    parameter int TAG_WIDTH    = `CACHE_T,
    parameter int OFFSET_WIDTH = `CACHE_B,
    parameter int WAYS         = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      write_i,
    input  logic [3:0]                wstrb_i,
    input  logic [TAG_WIDTH-1:0]      tag_i,
    input  logic [OFFSET_WIDTH-3:0]   offset_i,
    input  logic [31:0]               wdata_i,
    input  logic                      fill_start_i,
    input  logic                      fill_valid_i,
    input  logic [31:0]               fill_data_i,
    output logic                      hit_o,
    output logic [$clog2(WAYS)-1:0]   hit_way_o,
    output logic [31:0]               rdata_o,
    output logic [$clog2(WAYS)-1:0]   victim_way_o,
    output logic                      victim_valid_o,
    output logic                      victim_dirty_o,
    output logic [TAG_WIDTH-1:0]      victim_tag_o,
    output logic [31:0]               evict_data_o,
    output logic                      fill_busy_o,
    output logic                      fill_done_o
);

    localparam int DATA_W = 32;
    localparam int AW     = $clog2(WAYS);
    localparam int WW     = OFFSET_WIDTH - 2;
    localparam int WORDS  = 1 << WW;

    logic [WAYS-1:0]      valid_q;
    logic [WAYS-1:0]      dirty_q;
    logic [TAG_WIDTH-1:0] tag_q  [WAYS];
    logic [DATA_W-1:0]    data_q [WAYS][WORDS];
    logic [AW-1:0]        age_q  [WAYS];
    logic [AW-1:0]        age_d  [WAYS];

    logic                 fill_busy_q;
    logic                 fill_done_q;
    logic [AW-1:0]        fill_way_q;
    logic [TAG_WIDTH-1:0] fill_tag_q;
    logic [WW-1:0]        fill_cnt_q;

    logic                 hit_raw;
    logic [AW-1:0]        hit_way;
    logic                 inv_found;
    logic [AW-1:0]        inv_way;
    logic [AW-1:0]        lru_way;
    logic [AW-1:0]        sel_victim;

    logic                 fill_accept;
    logic                 fill_wr;
    logic                 fill_last;
    logic                 access_en;
    logic                 store_en;
    logic                 touch_en;
    logic [AW-1:0]        touch_way;
    logic [3:0]           store_be;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [3:0]        be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

`ifdef CACHE_WSTRB_EN
    assign store_be = wstrb_i;
`else
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb_i;
    assign store_be     = 4'hF;
`endif

    // Lowest-index matching way wins if tags were ever duplicated.
    always_comb begin
        hit_raw = 1'b0;
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == tag_i)) begin
                hit_raw = 1'b1;
                hit_way = AW'(i);
            end
        end
    end

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_way   = AW'(i);
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] == AW'(WAYS - 1)) begin
                lru_way = AW'(i);
            end
        end
        sel_victim = inv_found ? inv_way : lru_way;
    end

    assign hit_o          = hit_raw & ~fill_busy_q;
    assign hit_way_o      = hit_o ? hit_way : '0;
    assign rdata_o        = hit_o ? data_q[hit_way][offset_i] : '0;

    assign victim_way_o   = fill_busy_q ? fill_way_q : sel_victim;
    assign victim_valid_o = valid_q[victim_way_o];
    assign victim_dirty_o = dirty_q[victim_way_o];
    assign victim_tag_o   = tag_q[victim_way_o];
    assign evict_data_o   = data_q[victim_way_o][offset_i];

    assign fill_busy_o    = fill_busy_q;
    assign fill_done_o    = fill_done_q;

    // A refill request in the same cycle pre-empts any access, so the access neither writes nor touches.
    assign fill_accept = fill_start_i & ~fill_busy_q;
    assign access_en   = req_i & hit_o & ~fill_start_i;
    assign store_en    = access_en & write_i;
    assign fill_wr     = fill_busy_q & fill_valid_i;
    assign fill_last   = fill_wr & (fill_cnt_q == WW'(WORDS - 1));
    assign touch_en    = access_en | fill_last;
    assign touch_way   = fill_last ? fill_way_q : hit_way;

    always_comb begin
        for (int j = 0; j < WAYS; j++) begin
            age_d[j] = age_q[j];
        end
        if (touch_en) begin
            for (int j = 0; j < WAYS; j++) begin
                if (AW'(j) == touch_way) begin
                    age_d[j] = '0;
                end else if (age_q[j] < age_q[touch_way]) begin
                    age_d[j] = age_q[j] + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
            fill_way_q  <= '0;
            fill_tag_q  <= '0;
            fill_cnt_q  <= '0;
            for (int i = 0; i < WAYS; i++) begin
                tag_q[i] <= '0;
                age_q[i] <= AW'(WAYS - 1 - i);
                for (int w = 0; w < WORDS; w++) begin
                    data_q[i][w] <= '0;
                end
            end
        end else begin
            fill_done_q <= fill_last;
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= age_d[i];
            end

            if (fill_accept) begin
                fill_way_q           <= sel_victim;
                fill_tag_q           <= tag_i;
                valid_q[sel_victim]  <= 1'b0;
                dirty_q[sel_victim]  <= 1'b0;
                fill_busy_q          <= 1'b1;
                fill_cnt_q           <= '0;
            end

            if (fill_wr) begin
                data_q[fill_way_q][fill_cnt_q] <= fill_data_i;
                fill_cnt_q                     <= fill_cnt_q + WW'(1);
                if (fill_last) begin
                    valid_q[fill_way_q] <= 1'b1;
                    dirty_q[fill_way_q] <= 1'b0;
                    tag_q[fill_way_q]   <= fill_tag_q;
                    fill_busy_q         <= 1'b0;
                end
            end

            if (store_en) begin
                data_q[hit_way][offset_i] <= merge_bytes(data_q[hit_way][offset_i], wdata_i, store_be);
                dirty_q[hit_way]          <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_set.sv
// Directed bench for cache_set (4 ways, 4 words per line, 8-bit tags) with a queue-based scoreboard.
module tb_cache_set;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        write_i;
    logic [3:0]  wstrb_i;
    logic [7:0]  tag_i;
    logic [1:0]  offset_i;
    logic [31:0] wdata_i;
    logic        fill_start_i;
    logic        fill_valid_i;
    logic [31:0] fill_data_i;
    logic        hit_o;
    logic [1:0]  hit_way_o;
    logic [31:0] rdata_o;
    logic [1:0]  victim_way_o;
    logic        victim_valid_o;
    logic        victim_dirty_o;
    logic [7:0]  victim_tag_o;
    logic [31:0] evict_data_o;
    logic        fill_busy_o;
    logic        fill_done_o;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    string       name_q[$];
    logic [63:0] exp_q[$];

    cache_set #(.TAG_WIDTH(8), .OFFSET_WIDTH(4), .WAYS(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .write_i(write_i), .wstrb_i(wstrb_i),
        .tag_i(tag_i), .offset_i(offset_i), .wdata_i(wdata_i), .fill_start_i(fill_start_i),
        .fill_valid_i(fill_valid_i), .fill_data_i(fill_data_i), .hit_o(hit_o), .hit_way_o(hit_way_o),
        .rdata_o(rdata_o), .victim_way_o(victim_way_o), .victim_valid_o(victim_valid_o),
        .victim_dirty_o(victim_dirty_o), .victim_tag_o(victim_tag_o), .evict_data_o(evict_data_o),
        .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (fill_done_o) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input string n, input logic [63:0] e);
        name_q.push_back(n);
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        string       n;
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty: observed=%0h required=<queued expectation>", obs);
        end else begin
            n = name_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s: observed=%0h required=%0h", n, obs, e);
            end
        end
    endtask

    task automatic chk(input string n, input logic [63:0] obs, input logic [63:0] e);
        push_exp(n, e);
        pop_check(obs);
    endtask

    function automatic logic [63:0] pack_ld(input logic h, input logic [1:0] w, input logic [31:0] d);
        return {29'd0, h, w, d};
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic fill_begin(input logic [7:0] t);
        fill_start_i = 1'b1;
        tag_i        = t;
        tick();
        fill_start_i = 1'b0;
    endtask

    task automatic fill_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fill_valid_i = 1'b1;
            fill_data_i  = base + 32'(i);
            tick();
        end
        fill_valid_i = 1'b0;
    endtask

    task automatic fill(input logic [7:0] t, input logic [31:0] base);
        fill_begin(t);
        fill_words(base, 4);
        tick();
    endtask

    task automatic load(input string n, input logic [7:0] t, input logic [1:0] off,
                        input logic eh, input logic [1:0] ew, input logic [31:0] ed);
        req_i    = 1'b1;
        write_i  = 1'b0;
        tag_i    = t;
        offset_i = off;
        push_exp(n, pack_ld(eh, ew, ed));
        @(negedge clk_i);
        pop_check(pack_ld(hit_o, hit_way_o, rdata_o));
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
    endtask

    task automatic store(input logic [7:0] t, input logic [1:0] off, input logic [31:0] d, input logic [3:0] s);
        req_i    = 1'b1;
        write_i  = 1'b1;
        tag_i    = t;
        offset_i = off;
        wdata_i  = d;
        wstrb_i  = s;
        tick();
        req_i   = 1'b0;
        write_i = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_st;
        rst_i = 1'b1; req_i = 1'b0; write_i = 1'b0; wstrb_i = 4'h0; tag_i = '0; offset_i = '0;
        wdata_i = '0; fill_start_i = 1'b0; fill_valid_i = 1'b0; fill_data_i = '0;

        // Reset state
        do_reset();
        tag_i = 8'h12;
        @(negedge clk_i);
        chk("rst_hit", hit_o, 0);
        chk("rst_victim_way", victim_way_o, 0);
        chk("rst_victim_valid", victim_valid_o, 0);
        chk("rst_busy", fill_busy_o, 0);
        chk("rst_done", fill_done_o, 0);
        tick();

        // Basic refill then load
        done_cnt = 0;
        fill_begin(8'h12);
        chk("fill_busy_set", fill_busy_o, 1);
        chk("fill_latched_way", victim_way_o, 0);
        fill_words(32'hA0A0_0000, 4);
        chk("fill_busy_drop", fill_busy_o, 0);
        chk("fill_done_pulse", fill_done_o, 1);
        tick();
        chk("fill_done_low", fill_done_o, 0);
        tick();
        chk("fill_done_count", done_cnt, 1);
        load("load_a2", 8'h12, 2'd2, 1'b1, 2'd0, 32'hA0A0_0002);
        load("load_miss", 8'h13, 2'd2, 1'b0, 2'd0, 32'h0);

        // LRU replacement
        do_reset();
        for (int t = 1; t <= 4; t++) fill(8'(t), 32'h0100_0000 * 32'(t));
        load("lru_load_t1", 8'd1, 2'd1, 1'b1, 2'd0, 32'h0100_0001);
        @(negedge clk_i);
        chk("lru_victim_way", victim_way_o, 1);
        chk("lru_victim_tag", victim_tag_o, 2);
        chk("lru_victim_clean", victim_dirty_o, 0);
        tick();
        fill(8'd5, 32'h0500_0000);
        load("lru_t2_gone", 8'd2, 2'd0, 1'b0, 2'd0, 32'h0);
        load("lru_t5_way1", 8'd5, 2'd3, 1'b1, 2'd1, 32'h0500_0003);
        load("lru_t1_kept", 8'd1, 2'd0, 1'b1, 2'd0, 32'h0100_0000);

        // Byte-enabled store, dirty victim
        do_reset();
        fill(8'h33, 32'h1122_3344);
        store(8'h33, 2'd0, 32'hDEAD_BEEF, 4'b0011);
`ifdef CACHE_WSTRB_EN
        exp_st = 32'h1122_BEEF;
`else
        exp_st = 32'hDEAD_BEEF;
`endif
        load("store_merge", 8'h33, 2'd0, 1'b1, 2'd0, exp_st);
        fill(8'h34, 32'h3400_0000);
        fill(8'h35, 32'h3500_0000);
        fill(8'h36, 32'h3600_0000);
        offset_i = 2'd0;
        @(negedge clk_i);
        chk("dirty_victim_way", victim_way_o, 0);
        chk("dirty_victim_valid", victim_valid_o, 1);
        chk("dirty_victim_dirty", victim_dirty_o, 1);
        chk("dirty_victim_tag", victim_tag_o, 8'h33);
        chk("dirty_evict_data", evict_data_o, exp_st);
        tick();

        // Reset during a refill, stray fill_valid
        do_reset();
        fill(8'h40, 32'h4000_0000);
        tick();
        done_cnt = 0;
        fill_begin(8'h44);
        fill_words(32'h4400_0000, 2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_busy", fill_busy_o, 0);
        chk("abort_done", fill_done_o, 0);
        fill_valid_i = 1'b1;
        fill_data_i  = 32'hFFFF_FFFF;
        tick();
        fill_valid_i = 1'b0;
        chk("stray_valid_busy", fill_busy_o, 0);
        tick();
        tick();
        chk("abort_no_done", done_cnt, 0);
        load("abort_miss_40", 8'h40, 2'd0, 1'b0, 2'd0, 32'h0);
        load("abort_miss_44", 8'h44, 2'd1, 1'b0, 2'd0, 32'h0);
        @(negedge clk_i);
        chk("abort_victim_valid", victim_valid_o, 0);
        tick();

        // fill_start together with a store hit
        do_reset();
        fill(8'h50, 32'h5050_0000);
        req_i = 1'b1; write_i = 1'b1; tag_i = 8'h50; offset_i = 2'd1;
        wdata_i = 32'hCAFE_F00D; wstrb_i = 4'hF; fill_start_i = 1'b1;
        @(negedge clk_i);
        chk("coll_hit_before", hit_o, 1);
        tick();
        fill_start_i = 1'b0;
        @(negedge clk_i);
        chk("coll_busy", fill_busy_o, 1);
        chk("coll_busy_no_hit", hit_o, 0);
        chk("coll_latched_way", victim_way_o, 1);
        tick();
        req_i = 1'b0; write_i = 1'b0;
        fill_words(32'h5151_0000, 4);
        tick();
        fill(8'h60, 32'h6000_0000);
        fill(8'h61, 32'h6100_0000);
        offset_i = 2'd1;
        @(negedge clk_i);
        chk("coll_victim_way", victim_way_o, 0);
        chk("coll_victim_clean", victim_dirty_o, 0);
        chk("coll_store_dropped", evict_data_o, 32'h5050_0001);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_set.md
CACHE_SET -- requirements
Module: cache_set

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default `CACHE_T, tag bits per line.
REQ-002 SHALL have parameter OFFSET_WIDTH, default `CACHE_B, byte-offset bits; words per line = 2**(OFFSET_WIDTH-2).
REQ-003 SHALL have parameter WAYS, default 4, associativity; power of two, at least 2.
REQ-004 SHALL have clk_i, input, 1, the single clock.
REQ-005 SHALL have rst_i, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have req_i, input, 1, access request for this cycle.
REQ-007 SHALL have write_i, input, 1, access is a store; otherwise a load.
REQ-008 SHALL have wstrb_i, input, 4, byte enables for a store.
REQ-009 SHALL have tag_i, input, TAG_WIDTH, lookup tag and fill tag.
REQ-010 SHALL have offset_i, input, OFFSET_WIDTH-2, word index for access and evict reads.
REQ-011 SHALL have wdata_i, input, 32, store data.
REQ-012 SHALL have fill_start_i, input, 1, begin refill of the victim way.
REQ-013 SHALL have fill_valid_i, input, 1, fill_data_i carries the next refill word.
REQ-014 SHALL have fill_data_i, input, 32, refill word.
REQ-015 SHALL have hit_o, output, 1; hit_way_o, output, log2(WAYS); rdata_o, output, 32.
REQ-016 SHALL have victim_way_o, output, log2(WAYS); victim_valid_o, output, 1; victim_dirty_o, output, 1; victim_tag_o, output, TAG_WIDTH; evict_data_o, output, 32.
REQ-017 SHALL have fill_busy_o, output, 1, and fill_done_o, output, 1.

Function
REQ-018 hit_o SHALL be combinational: some valid way has tag equal to tag_i, and fill_busy_o is 0; hit_way_o is that way, or 0 on a miss.
REQ-019 rdata_o SHALL be the word at offset_i of the hit way, or 0 on a miss.
REQ-020 A store hit (req_i & write_i & hit_o) SHALL update the enabled bytes on the next edge and set that way's dirty bit.
REQ-021 A load miss or store miss SHALL change no state.
REQ-022 LRU: each way SHALL hold an age of log2(WAYS) bits, and the ages SHALL always form a permutation.
REQ-023 On a touch of way w (any hit with req_i, or fill completion), the age of w SHALL become 0 and every way younger than w SHALL increment by 1.
REQ-024 Victim selection SHALL be the lowest-index invalid way if any; otherwise the way with age WAYS-1.
REQ-025 victim_valid_o, victim_dirty_o and victim_tag_o SHALL describe the victim way; evict_data_o SHALL be its word at offset_i.
REQ-026 When fill_busy_o=0, fill_start_i SHALL latch the victim way and tag_i, clear that way's valid and dirty bits, set fill_busy_o, and zero the word counter.
REQ-027 While busy, each fill_valid_i SHALL write fill_data_i to the word at the counter in the latched way and increment the counter.
REQ-028 On the last word, the latched way SHALL be written valid, clean, with the latched tag, and touched; fill_busy_o SHALL drop, and fill_done_o SHALL pulse for exactly 1 cycle on the following cycle.
REQ-029 While busy, req_i SHALL be ignored; fill_start_i SHALL be ignored; and victim_* outputs SHALL show the latched way.
REQ-030 If fill_start_i and req_i arrive in the same cycle, fill_start_i SHALL win, and a store in that cycle SHALL be dropped.
REQ-031 fill_valid_i SHALL be ignored when not busy.

Reset
REQ-032 When rst_i is high, all valid, dirty, tag and data bits SHALL clear to 0.
REQ-033 When rst_i is high, age[i] SHALL be set to WAYS-1-i.
REQ-034 When rst_i is high, fill_busy_o, fill_done_o and the counter SHALL clear to 0; a fill in progress is aborted.
REQ-035 After reset, hit_o SHALL be 0, victim_way_o SHALL be 0 and victim_valid_o SHALL be 0.

Configuration
REQ-036 Macro CACHE_WSTRB_EN: when defined, wstrb_i SHALL gate bytes per REQ-020; when undefined, stores SHALL write all 4 bytes and wstrb_i is ignored.

Verification (WAYS=4, 4 words/line)
REQ-037 Reset, then fill_start_i with tag 0x12, then 4 fill words A0..A3 -> way0 valid, fill_done_o pulses once, and a load of tag 0x12, offset 2 returns A2 with hit_way_o=0.
REQ-038 Fill tags 1..4 into ways 0..3, then load tag 1 -> victim_way_o=1; a fifth fill replaces way1.
REQ-039 Store 0xDEADBEEF with wstrb 0b0011 over 0x11223344 -> 0x1122BEEF when the macro is defined, 0xDEADBEEF when it is undefined; victim_dirty_o=1 when that way is the victim.
REQ-040 Assert rst_i after 2 of 4 fill words -> fill_busy_o=0, no fill_done_o pulse, and all lookups miss.
REQ-041 Assert fill_start_i together with a store hit -> the store is dropped and fill_busy_o=1 on the next cycle.
